// File: rtl/hs_backend_pkg.sv
// Shared definitions for the hs_backend instruction backend: opcodes, FSM
// states and instruction field extraction for any register-index width.
package hs_backend_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_ACK_HI = 2'd2
    } state_e;

    // Extractors work on a zero-extended instruction so one set of functions
    // serves every NREG; callers narrow the result to their own RIDX_W.
    localparam int unsigned MAX_RIDX_W = 8;
    localparam int unsigned MAX_INST_W = 2 + 3 * MAX_RIDX_W;

    typedef logic [MAX_INST_W-1:0] inst_wide_t;
    typedef logic [MAX_RIDX_W-1:0] ridx_wide_t;

    function automatic inst_wide_t field_mask(input int unsigned ridx_w);
        return (inst_wide_t'(1) << ridx_w) - inst_wide_t'(1);
    endfunction

    function automatic logic [1:0] field_op(input inst_wide_t inst, input int unsigned ridx_w);
        return 2'((inst >> (3 * ridx_w)) & inst_wide_t'(3));
    endfunction

    function automatic ridx_wide_t field_rs1(input inst_wide_t inst, input int unsigned ridx_w);
        return ridx_wide_t'((inst >> (2 * ridx_w)) & field_mask(ridx_w));
    endfunction

    function automatic ridx_wide_t field_rs2(input inst_wide_t inst, input int unsigned ridx_w);
        return ridx_wide_t'((inst >> ridx_w) & field_mask(ridx_w));
    endfunction

    function automatic ridx_wide_t field_rd(input inst_wide_t inst, input int unsigned ridx_w);
        return ridx_wide_t'(inst & field_mask(ridx_w));
    endfunction

endpackage

// File: rtl/hs_backend_alu.sv
// Combinational execute unit: maps opcode and operands to the value written
// back and whether a write happens at all.
module hs_backend_alu
    import hs_backend_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMM_W  = 4
) (
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] rs1_val_i,
    input  logic [DATA_W-1:0] rs2_val_i,
    input  logic [IMM_W-1:0]  imm_i,
    output logic [DATA_W-1:0] result_o,
    output logic              we_o
);

    always_comb begin
        // NOTE: both outputs get a default before the case so no path leaves
        // them unassigned; a missing default here would infer latches.
        result_o = '0;
        we_o     = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = rs1_val_i + rs2_val_i;
                we_o     = 1'b1;
            end
            OP_SET: begin
                result_o = DATA_W'(imm_i);
                we_o     = 1'b1;
            end
            OP_NAND: begin
                result_o = ~(rs1_val_i & rs2_val_i);
                we_o     = 1'b1;
            end
            default: begin
                result_o = '0;
                we_o     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hs_backend.sv
// 4-phase req/ack instruction backend with NREG x DATA_W register file and
// retire counter. Optional retire trace port with `define HS_BACKEND_TRACE_EN.
module hs_backend
    import hs_backend_pkg::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int NREG        = 4,
    parameter  int PC_W        = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int RIDX_W      = $clog2(NREG),
    localparam int INST_W      = 2 + 3 * RIDX_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ipacket_req,
    output logic                   ipacket_ack,
    input  logic [PC_W-1:0]        ipacket_pc,
    input  logic [INST_W-1:0]      ipacket_inst,
    output logic [NREG*DATA_W-1:0] dbg_regs,
    output logic [15:0]            retire_cnt
`ifdef HS_BACKEND_TRACE_EN
    ,
    output logic                   retire_valid,
    output logic [PC_W-1:0]        retire_pc,
    output logic [RIDX_W-1:0]      retire_rd,
    output logic [DATA_W-1:0]      retire_data
`endif
);

    logic req_s;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign req_s = ipacket_req;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // NOTE: sequential state uses <= so every flop samples pre-edge
            // values; blocking = would collapse the chain in simulation.
            always_ff @(posedge clk) begin
                if (!rst_n) sync_q <= '0;
                else        sync_q <= SYNC_STAGES'({sync_q, ipacket_req});
            end

            assign req_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    state_e                         state_q, state_d;
    logic                           ack_q, ack_d;
    logic [INST_W-1:0]              inst_q, inst_d;
    logic [15:0]                    cnt_q, cnt_d;
    logic [NREG-1:0][DATA_W-1:0]    regs_q, regs_d;

    logic [1:0]        op;
    logic [RIDX_W-1:0] rs1_idx, rs2_idx, rd_idx;
    logic [DATA_W-1:0] alu_result;
    logic              alu_we;

    assign op      = field_op(inst_wide_t'(inst_q), RIDX_W);
    assign rs1_idx = RIDX_W'(field_rs1(inst_wide_t'(inst_q), RIDX_W));
    assign rs2_idx = RIDX_W'(field_rs2(inst_wide_t'(inst_q), RIDX_W));
    assign rd_idx  = RIDX_W'(field_rd(inst_wide_t'(inst_q), RIDX_W));

    hs_backend_alu #(
        .DATA_W (DATA_W),
        .IMM_W  (2 * RIDX_W)
    ) u_alu (
        .op_i      (op),
        .rs1_val_i (regs_q[rs1_idx]),
        .rs2_val_i (regs_q[rs2_idx]),
        .imm_i     ({rs1_idx, rs2_idx}),
        .result_o  (alu_result),
        .we_o      (alu_we)
    );

`ifdef HS_BACKEND_TRACE_EN
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              trace_valid_q, trace_valid_d;
    logic [PC_W-1:0]   trace_pc_q, trace_pc_d;
    logic [RIDX_W-1:0] trace_rd_q, trace_rd_d;
    logic [DATA_W-1:0] trace_data_q, trace_data_d;
`else
    logic unused_pc;
    assign unused_pc = ^ipacket_pc;
`endif

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
`ifdef HS_BACKEND_TRACE_EN
        pc_d          = pc_q;
        trace_valid_d = 1'b0;
        trace_pc_d    = trace_pc_q;
        trace_rd_d    = trace_rd_q;
        trace_data_d  = trace_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    inst_d  = ipacket_inst;
`ifdef HS_BACKEND_TRACE_EN
                    pc_d    = ipacket_pc;
`endif
                    state_d = ST_EXEC;
                end
            end
            // Retires regardless of req_s: a req drop here is a feeder
            // protocol error and the packet still completes.
            ST_EXEC: begin
                if (alu_we) regs_d[rd_idx] = alu_result;
                cnt_d   = cnt_q + 16'd1;
                ack_d   = 1'b1;
                state_d = ST_ACK_HI;
`ifdef HS_BACKEND_TRACE_EN
                trace_valid_d = 1'b1;
                trace_pc_d    = pc_q;
                trace_rd_d    = alu_we ? rd_idx : '0;
                trace_data_d  = alu_we ? alu_result : '0;
`endif
            end
            ST_ACK_HI: begin
                if (req_s) ack_d   = 1'b1;
                else       state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            inst_q  <= '0;
            cnt_q   <= '0;
            // NOTE: the register file is flops observable on dbg_regs, so it
            // is reset; a RAM-style array would normally be left unreset.
            regs_q  <= '0;
`ifdef HS_BACKEND_TRACE_EN
            pc_q          <= '0;
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_rd_q    <= '0;
            trace_data_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
`ifdef HS_BACKEND_TRACE_EN
            pc_q          <= pc_d;
            trace_valid_q <= trace_valid_d;
            trace_pc_q    <= trace_pc_d;
            trace_rd_q    <= trace_rd_d;
            trace_data_q  <= trace_data_d;
`endif
        end
    end

    assign ipacket_ack = ack_q;
    assign dbg_regs    = regs_q;
    assign retire_cnt  = cnt_q;

`ifdef HS_BACKEND_TRACE_EN
    assign retire_valid = trace_valid_q;
    assign retire_pc    = trace_pc_q;
    assign retire_rd    = trace_rd_q;
    assign retire_data  = trace_data_q;
`endif

endmodule

// File: tb/tb_hs_backend.sv
// Self-checking bench for hs_backend: three instances (8b/4reg/2 sync,
// 16b/8reg/0 sync, 8b/4reg/3 sync) driven by directed handshakes and a scoreboard.
module tb_hs_backend;
    import hs_backend_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [2:0]   req;
    logic [2:0]   ack;
    logic [7:0]   pc;
    logic [10:0]  inst;
    logic [31:0]  dbg0, dbg2;
    logic [127:0] dbg1;
    logic [15:0]  cnt0, cnt1, cnt2;
`ifdef HS_BACKEND_TRACE_EN
    logic [2:0]   tv;
    logic [7:0]   tpc0, tpc1, tpc2;
    logic [1:0]   trd0, trd2;
    logic [2:0]   trd1;
    logic [7:0]   td0, td2;
    logic [15:0]  td1;
`endif

    hs_backend #(.DATA_W(8), .NREG(4), .PC_W(8), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .ipacket_req(req[0]), .ipacket_ack(ack[0]),
        .ipacket_pc(pc), .ipacket_inst(inst[7:0]), .dbg_regs(dbg0), .retire_cnt(cnt0)
`ifdef HS_BACKEND_TRACE_EN
        , .retire_valid(tv[0]), .retire_pc(tpc0), .retire_rd(trd0), .retire_data(td0)
`endif
    );

    hs_backend #(.DATA_W(16), .NREG(8), .PC_W(8), .SYNC_STAGES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .ipacket_req(req[1]), .ipacket_ack(ack[1]),
        .ipacket_pc(pc), .ipacket_inst(inst), .dbg_regs(dbg1), .retire_cnt(cnt1)
`ifdef HS_BACKEND_TRACE_EN
        , .retire_valid(tv[1]), .retire_pc(tpc1), .retire_rd(trd1), .retire_data(td1)
`endif
    );

    hs_backend #(.DATA_W(8), .NREG(4), .PC_W(8), .SYNC_STAGES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .ipacket_req(req[2]), .ipacket_ack(ack[2]),
        .ipacket_pc(pc), .ipacket_inst(inst[7:0]), .dbg_regs(dbg2), .retire_cnt(cnt2)
`ifdef HS_BACKEND_TRACE_EN
        , .retire_valid(tv[2]), .retire_pc(tpc2), .retire_rd(trd2), .retire_data(td2)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [127:0] regs;
        logic [15:0]  cnt;
        logic [7:0]   pc;
        int           rd;
        logic [15:0]  data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mreg [3][8];
    logic [15:0] mcnt [3];

    function automatic int ridx_of(input int w);
        return (w == 1) ? 3 : 2;
    endfunction

    function automatic int dw_of(input int w);
        return (w == 1) ? 16 : 8;
    endfunction

    function automatic int sync_of(input int w);
        case (w)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [10:0] enc(input int w, input logic [1:0] op,
                                        input int rs1, input int rs2, input int rd);
        int r;
        r = ridx_of(w);
        return 11'((int'(op) << (3 * r)) | (rs1 << (2 * r)) | (rs2 << r) | rd);
    endfunction

    function automatic logic [127:0] model_flat(input int w);
        logic [127:0] f;
        f = '0;
        for (int i = 0; i < (1 << ridx_of(w)); i++)
            f = f | (128'(mreg[w][i]) << (i * dw_of(w)));
        return f;
    endfunction

    function automatic logic [127:0] dut_flat(input int w);
        case (w)
            0:       return 128'(dbg0);
            1:       return dbg1;
            default: return 128'(dbg2);
        endcase
    endfunction

    function automatic logic [15:0] dut_cnt(input int w);
        case (w)
            0:       return cnt0;
            1:       return cnt1;
            default: return cnt2;
        endcase
    endfunction

    task automatic reset_model();
        for (int w = 0; w < 3; w++) begin
            mcnt[w] = '0;
            for (int i = 0; i < 8; i++) mreg[w][i] = '0;
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ISA reference model: runs at drive time and queues what the DUT must show.
    task automatic push_exp(input int w, input logic [1:0] op, input int rs1,
                            input int rs2, input int rd, input logic [7:0] pcv);
        exp_t        e;
        logic [15:0] a, b, r, mask;
        mask = (w == 1) ? 16'hFFFF : 16'h00FF;
        a    = mreg[w][rs1];
        b    = mreg[w][rs2];
        case (op)
            OP_ADD:  r = (a + b) & mask;
            OP_SET:  r = 16'((rs1 << ridx_of(w)) | rs2);
            OP_NAND: r = ~(a & b) & mask;
            default: r = '0;
        endcase
        if (op != OP_NOP) mreg[w][rd] = r;
        mcnt[w] = mcnt[w] + 16'd1;
        e.regs  = model_flat(w);
        e.cnt   = mcnt[w];
        e.pc    = pcv;
        e.rd    = (op == OP_NOP) ? 0 : rd;
        e.data  = r;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int w, input logic lvl, output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (ack[w] === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_head(input int w);
        exp_t e;
        check("sb_depth", 128'(sb.size()), 128'(1));
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("regs", dut_flat(w), e.regs);
        check("retire_cnt", 128'(dut_cnt(w)), 128'(e.cnt));
`ifdef HS_BACKEND_TRACE_EN
        if (w == 0) begin
            check("trace_valid", 128'(tv[0]), 128'(1));
            check("trace_pc", 128'(tpc0), 128'(e.pc));
            check("trace_rd", 128'(trd0), 128'(e.rd));
            check("trace_data", 128'(td0), 128'(e.data));
        end
`endif
    endtask

    task automatic send(input int w, input logic [1:0] op, input int rs1, input int rs2,
                        input int rd, input logic [7:0] pcv, input int hold);
        int n;
        push_exp(w, op, rs1, rs2, rd, pcv);
        @(posedge clk);
        #1;
        pc     = pcv;
        inst   = enc(w, op, rs1, rs2, rd);
        req[w] = 1'b1;
        wait_ack(w, 1'b1, n);
        check("rise_latency", 128'(n), 128'(sync_of(w) + 2));
        check_head(w);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("ack_hold", 128'(ack[w]), 128'(1));
`ifdef HS_BACKEND_TRACE_EN
            if (w == 0) check("trace_pulse_end", 128'(tv[0]), 128'(0));
`endif
        end
        req[w] = 1'b0;
        wait_ack(w, 1'b0, n);
        check("fall_latency", 128'(n), 128'(sync_of(w) + 1));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        req   = '0;
        pc    = '0;
        inst  = '0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 128'(ack), 128'(0));
        check("rst_regs0", 128'(dbg0), 128'(0));
        check("rst_regs1", dbg1, 128'(0));
        check("rst_cnt", 128'({cnt0, cnt1, cnt2}), 128'(0));
`ifdef HS_BACKEND_TRACE_EN
        check("rst_trace", 128'({tv, tpc0, trd0, td0}), 128'(0));
`endif
        rst_n = 1'b1;

        // Reference program on the 8-bit / 4-register instance.
        send(0, OP_SET,  0, 0, 0, 8'h10, 0);
        send(0, OP_SET,  0, 1, 1, 8'h11, 0);
        send(0, OP_SET,  0, 2, 2, 8'h12, 0);
        send(0, OP_SET,  0, 3, 3, 8'h13, 0);
        send(0, OP_ADD,  2, 3, 0, 8'h14, 0);
        send(0, OP_ADD,  0, 2, 0, 8'h15, 0);
        send(0, OP_ADD,  2, 0, 2, 8'h16, 0);
        send(0, OP_NAND, 2, 0, 2, 8'h17, 0);
        check("prog_regs", 128'(dbg0), 128'(32'h03FE_0107));
        check("prog_cnt", 128'(cnt0), 128'(8));

        send(0, OP_NAND, 1, 1, 1, 8'h20, 0);
        send(0, OP_ADD,  1, 2, 0, 8'h21, 0);
        check("carry_drop", 128'(dbg0[15:0]), 128'(16'hFEFC));

        // Zero-sync, 16-bit, 8-register instance.
        send(1, OP_SET,  7, 7, 7, 8'h30, 2);
        check("set_r7", 128'(dbg1[127:112]), 128'(16'h003F));
        send(1, OP_NAND, 0, 0, 6, 8'h31, 0);
        send(1, OP_SET,  0, 1, 5, 8'h32, 0);
        send(1, OP_ADD,  6, 5, 6, 8'h33, 0);
        check("wrap_16", 128'(dbg1[111:96]), 128'(16'h0000));

        // Three-stage synchroniser instance.
        send(2, OP_SET,  1, 1, 1, 8'h40, 3);
        check("sync3_r1", 128'(dbg2[15:8]), 128'(8'h05));

        // NOP retires but writes nothing.
        send(0, OP_NOP,  1, 2, 3, 8'h09, 1);
        check("nop_cnt", 128'(cnt0), 128'(11));

        // Reset while ack is high, then release with req still asserted.
        @(posedge clk);
        #1;
        pc     = 8'h42;
        inst   = enc(0, OP_SET, 1, 2, 3);
        req[0] = 1'b1;
        wait_ack(0, 1'b1, n);
        check("pre_rst_ack_lat", 128'(n), 128'(4));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ack", 128'(ack[0]), 128'(0));
        check("midrst_regs", 128'(dbg0), 128'(0));
        check("midrst_cnt", 128'(cnt0), 128'(0));
        rst_n = 1'b1;
        reset_model();
        push_exp(0, OP_SET, 1, 2, 3, 8'h42);
        wait_ack(0, 1'b1, n);
        check("rerun_latency", 128'(n), 128'(4));
        check_head(0);
        check("rerun_cnt", 128'(cnt0), 128'(1));
        req[0] = 1'b0;
        wait_ack(0, 1'b0, n);
        check("rerun_fall", 128'(n), 128'(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
